// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants (state encoding, XLEN, nop word)
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;
  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_t;
endpackage

// File: rtl/if_next_pc.sv
// if_next_pc: redirect detect and target mux (branch_taken/branch_target, jump/jump_target -> redirect, target; branch wins)
module if_next_pc
  import cpu_pkg::*;
(
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic            redirect,
  output logic [XLEN-1:0] target
);
  assign redirect = branch_taken | jump;
  assign target = branch_taken ? branch_target : jump_target;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage PC + imem req/ack fetch FSM feeding IF/ID (clk, rst_n, stall, branch/jump redirects, imem_req/addr/ack/rdata, PCPlus4_IF/Instr_IF/valid_IF); IF_PERF_CNT_EN adds perf_fetch_cnt/perf_stall_cnt/perf_redirect_cnt
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PCPlus4_IF,
  output logic [XLEN-1:0] Instr_IF,
  output logic            valid_IF
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_redirect_cnt
`endif
);
  state_t state, state_n;
  logic [XLEN-1:0] pc, pc_n, pc_inc, hold_instr, redirect_pc, target;
  logic redirect, in_fetch, in_hold, in_drain, ack, advance;
  if_next_pc u_next_pc (
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .redirect     (redirect),
    .target       (target)
  );
  always_comb begin
    in_hold = state == HOLD;
    in_drain = state == DRAIN;
    in_fetch = ~in_hold & ~in_drain;
    ack = imem_ack & ~in_hold;
    pc_inc = pc + PC_STEP;
    imem_req = ~in_hold;
    imem_addr = pc;
    valid_IF = ~redirect & (in_hold | (in_fetch & ack));
    Instr_IF = ~valid_IF ? NOP_INSTR : in_hold ? hold_instr : imem_rdata;
    PCPlus4_IF = pc_inc;
    advance = valid_IF & ~stall;
    state_n = in_hold  ? ((redirect | ~stall) ? FETCH : HOLD)
            : in_drain ? (ack ? FETCH : DRAIN)
            : ack      ? ((stall & ~redirect) ? HOLD : FETCH)
            : redirect ? DRAIN : FETCH;
    // a redirect seen while a fetch is still outstanding is parked in redirect_pc until the ack
    pc_n = (redirect & (in_hold | ack)) ? target
         : (in_drain & ack)             ? redirect_pc
         : advance                      ? pc_inc
         : pc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc <= RESET_PC;
      hold_instr <= NOP_INSTR;
      redirect_pc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      if (in_fetch & ack) hold_instr <= imem_rdata;
      if (redirect) redirect_pc <= target;
    end
  end
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + {31'd0, advance};
      perf_stall_cnt <= perf_stall_cnt + {31'd0, in_hold | (in_fetch & ~ack)};
      perf_redirect_cnt <= perf_redirect_cnt + {31'd0, redirect};
    end
  end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios plus randomized program-order scoreboard for if_fetch_unit
module tb_if_fetch_unit;
  logic clk = 0, rst_n = 1, stall = 0, branch_taken = 0, jump = 0, imem_ack = 0;
  logic [31:0] branch_target = 0, jump_target = 0, imem_rdata = 0;
  logic imem_req, valid_IF;
  logic [31:0] imem_addr, PCPlus4_IF, Instr_IF;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .PCPlus4_IF(PCPlus4_IF), .Instr_IF(Instr_IF), .valid_IF(valid_IF)
  );
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction
  task automatic do_reset;
    @(negedge clk);
    rst_n = 0;
    {stall, branch_taken, jump, imem_ack} = '0;
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic set_in(input logic s, input logic a, input logic bt, input logic [31:0] btg,
                        input logic j, input logic [31:0] jtg);
    @(negedge clk);
    stall = s; imem_ack = a; branch_taken = bt; branch_target = btg; jump = j; jump_target = jtg;
    imem_rdata = mem_f(imem_addr);
    #1;
  endtask
  task automatic test_reset;
    #2 rst_n = 0;
    #2;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_req got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    checks++; if (valid_IF !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid_IF); end
    checks++; if (Instr_IF !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", Instr_IF); end
    checks++; if (PCPlus4_IF !== 32'h4) begin errors++; $display("FAIL rst_pcplus4 got %h want 4", PCPlus4_IF); end
    imem_ack = 1;
    @(negedge clk); #1;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_hold_addr got %h want 0", imem_addr); end
    imem_ack = 0;
    rst_n = 1;
  endtask
  task automatic test_zero_wait;
    do_reset;
    for (int i = 0; i < 6; i++) begin
      set_in(0, 1, 0, 0, 0, 0);
      checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL zw_addr got %h want %h", imem_addr, 32'(4 * i)); end
      checks++; if (valid_IF !== 1'b1 || Instr_IF !== mem_f(32'(4 * i))) begin errors++; $display("FAIL zw_instr got %b/%h want 1/%h", valid_IF, Instr_IF, mem_f(32'(4 * i))); end
      checks++; if (PCPlus4_IF !== 32'(4 * i + 4)) begin errors++; $display("FAIL zw_pcplus4 got %h want %h", PCPlus4_IF, 32'(4 * i + 4)); end
    end
  endtask
  task automatic test_latency;
    do_reset;
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 0);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL lat_wait_req got %b/%h want 1/0", imem_req, imem_addr); end
      checks++; if (valid_IF !== 1'b0 || Instr_IF !== 32'h0) begin errors++; $display("FAIL lat_wait_valid got %b/%h want 0/0", valid_IF, Instr_IF); end
    end
    set_in(0, 1, 0, 0, 0, 0);
    checks++; if (imem_addr !== 32'h0 || valid_IF !== 1'b1 || Instr_IF !== mem_f(0)) begin errors++; $display("FAIL lat_ack got %h/%b/%h want 0/1/%h", imem_addr, valid_IF, Instr_IF, mem_f(0)); end
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (imem_addr !== 32'h4 || valid_IF !== 1'b0) begin errors++; $display("FAIL lat_next got %h/%b want 4/0", imem_addr, valid_IF); end
  endtask
  task automatic test_stall_hold;
    do_reset;
    for (int i = 0; i < 2; i++) set_in(0, 1, 0, 0, 0, 0);
    set_in(1, 1, 0, 0, 0, 0);
    checks++; if (imem_addr !== 32'h8 || valid_IF !== 1'b1 || Instr_IF !== mem_f(8)) begin errors++; $display("FAIL stall_ack got %h/%b/%h want 8/1/%h", imem_addr, valid_IF, Instr_IF, mem_f(8)); end
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 0, 0, 0, 0);
      checks++; if (imem_req !== 1'b0 || valid_IF !== 1'b1 || Instr_IF !== mem_f(8)) begin errors++; $display("FAIL hold got %b/%b/%h want 0/1/%h", imem_req, valid_IF, Instr_IF, mem_f(8)); end
      checks++; if (PCPlus4_IF !== 32'hC) begin errors++; $display("FAIL hold_pcplus4 got %h want c", PCPlus4_IF); end
    end
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (imem_req !== 1'b0 || valid_IF !== 1'b1 || Instr_IF !== mem_f(8)) begin errors++; $display("FAIL hold_release got %b/%b/%h want 0/1/%h", imem_req, valid_IF, Instr_IF, mem_f(8)); end
    set_in(0, 1, 0, 0, 0, 0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || Instr_IF !== mem_f(32'hC)) begin errors++; $display("FAIL after_hold got %b/%h/%h want 1/c/%h", imem_req, imem_addr, Instr_IF, mem_f(32'hC)); end
  endtask
  task automatic test_branch_drain;
    do_reset;
    for (int i = 0; i < 4; i++) set_in(0, 1, 0, 0, 0, 0);
    set_in(0, 0, 1, 32'h100, 0, 0);
    checks++; if (imem_addr !== 32'h10 || valid_IF !== 1'b0) begin errors++; $display("FAIL br_wait got %h/%b want 10/0", imem_addr, valid_IF); end
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 0);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || valid_IF !== 1'b0) begin errors++; $display("FAIL drain got %b/%h/%b want 1/10/0", imem_req, imem_addr, valid_IF); end
    end
    set_in(0, 1, 0, 0, 0, 0);
    checks++; if (imem_addr !== 32'h10 || valid_IF !== 1'b0 || Instr_IF !== 32'h0) begin errors++; $display("FAIL drain_ack got %h/%b/%h want 10/0/0", imem_addr, valid_IF, Instr_IF); end
    set_in(0, 1, 0, 0, 0, 0);
    checks++; if (imem_addr !== 32'h100 || valid_IF !== 1'b1 || Instr_IF !== mem_f(32'h100)) begin errors++; $display("FAIL br_target got %h/%b/%h want 100/1/%h", imem_addr, valid_IF, Instr_IF, mem_f(32'h100)); end
  endtask
  task automatic test_branch_jump_hold;
    do_reset;
    set_in(0, 1, 0, 0, 0, 0);
    set_in(1, 1, 0, 0, 0, 0);
    set_in(1, 0, 1, 32'h40, 1, 32'h80);
    checks++; if (imem_req !== 1'b0 || valid_IF !== 1'b0 || Instr_IF !== 32'h0) begin errors++; $display("FAIL hold_redirect got %b/%b/%h want 0/0/0", imem_req, valid_IF, Instr_IF); end
    set_in(0, 1, 0, 0, 0, 0);
    checks++; if (imem_addr !== 32'h40 || valid_IF !== 1'b1 || Instr_IF !== mem_f(32'h40)) begin errors++; $display("FAIL prio_target got %h/%b/%h want 40/1/%h", imem_addr, valid_IF, Instr_IF, mem_f(32'h40)); end
    set_in(0, 1, 1, 32'h40, 1, 32'h80);
    checks++; if (imem_addr !== 32'h44 || valid_IF !== 1'b0) begin errors++; $display("FAIL fetch_redirect got %h/%b want 44/0", imem_addr, valid_IF); end
    set_in(0, 1, 0, 0, 0, 0);
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL prio_target2 got %h want 40", imem_addr); end
  endtask
  task automatic test_wrap_reset;
    do_reset;
    set_in(0, 1, 0, 0, 1, 32'hFFFF_FFFC);
    checks++; if (valid_IF !== 1'b0) begin errors++; $display("FAIL jmp_valid got %b want 0", valid_IF); end
    set_in(0, 1, 0, 0, 0, 0);
    checks++; if (imem_addr !== 32'hFFFF_FFFC || valid_IF !== 1'b1 || PCPlus4_IF !== 32'h0) begin errors++; $display("FAIL wrap_top got %h/%b/%h want fffffffc/1/0", imem_addr, valid_IF, PCPlus4_IF); end
    set_in(0, 1, 0, 0, 0, 0);
    checks++; if (imem_addr !== 32'h0 || Instr_IF !== mem_f(0)) begin errors++; $display("FAIL wrap_addr got %h/%h want 0/%h", imem_addr, Instr_IF, mem_f(0)); end
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin errors++; $display("FAIL mid_req got %h/%b want 4/1", imem_addr, imem_req); end
    #1 rst_n = 0;
    #1;
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || valid_IF !== 1'b0) begin errors++; $display("FAIL async_rst got %h/%b/%b want 0/1/0", imem_addr, imem_req, valid_IF); end
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_random;
    logic [31:0] exp_pc, req_addr;
    int lat, cnt, accepted;
    bit busy;
    do_reset;
    exp_pc = 0; req_addr = 0; busy = 0; cnt = 0; lat = 0; accepted = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      stall = $urandom_range(0, 9) < 3;
      branch_taken = $urandom_range(0, 15) == 0;
      jump = $urandom_range(0, 15) == 0;
      branch_target = 32'($urandom_range(0, 255)) << 2;
      jump_target = 32'($urandom_range(256, 511)) << 2;
      if (imem_req && !busy) begin busy = 1; cnt = 0; lat = $urandom_range(0, 3); req_addr = imem_addr; end
      imem_ack = busy && cnt == lat;
      imem_rdata = imem_ack ? mem_f(imem_addr) : 32'hDEAD_BEEF;
      #1;
      if (busy && cnt > 0) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== req_addr) begin errors++; $display("FAIL rnd_protocol got %b/%h want 1/%h", imem_req, imem_addr, req_addr); end
      end
      checks++; if (!valid_IF && Instr_IF !== 32'h0) begin errors++; $display("FAIL rnd_bubble got %h want 0", Instr_IF); end
      if (branch_taken || jump) begin
        checks++; if (valid_IF !== 1'b0) begin errors++; $display("FAIL rnd_redirect_valid got %b want 0", valid_IF); end
        exp_pc = branch_taken ? branch_target : jump_target;
      end else if (valid_IF && !stall) begin
        checks++; if (Instr_IF !== mem_f(exp_pc) || PCPlus4_IF !== exp_pc + 4) begin errors++; $display("FAIL rnd_accept got %h/%h want %h/%h", Instr_IF, PCPlus4_IF, mem_f(exp_pc), exp_pc + 4); end
        exp_pc += 4;
        accepted++;
      end
      if (imem_ack) busy = 0; else if (busy) cnt++;
    end
    checks++; if (accepted < 200) begin errors++; $display("FAIL rnd_progress got %0d want >=200", accepted); end
    imem_ack = 0; stall = 0; branch_taken = 0; jump = 0;
  endtask
  initial begin
    test_reset;
    test_zero_wait;
    test_latency;
    test_stall_hold;
    test_branch_drain;
    test_branch_jump_hold;
    test_wrap_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
